// File: rtl/uart_tx.sv
// uart_tx: LSB-first async serializer driven by a 4x baud tick, with a one-word holding register.
// Define UART_TX_PARITY_EN to add a parity bit and the parity_odd_in port.
module uart_tx #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clock_in,
    input  logic                 n_reset_in,
    input  logic                 tick_in,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 two_stop_in,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd_in,
`endif
    output logic                 tx_out,
    output logic                 busy_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [1:0]           sub_q, sub_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 two_stop_q, two_stop_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic accept;
    logic bit_end;
    logic load;

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        two_stop_d  = two_stop_q;
        stop2_d     = stop2_q;
        tx_d        = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        load        = 1'b0;
        accept      = valid_in && !hold_full_q;
        bit_end     = tick_in && (sub_q == 2'd3);

        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        if (tick_in && (state_q != S_IDLE)) begin
            sub_d = sub_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick_in && hold_full_q) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        stop2_d = two_stop_q;
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    stop2_d = two_stop_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // stop2_q marks a second stop bit still owed before the frame may end
                if (bit_end) begin
                    if (stop2_q) begin
                        stop2_d = 1'b0;
                    end else if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // load and accept are exclusive: load needs hold full, accept needs it empty
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            two_stop_d  = two_stop_in;
`ifdef UART_TX_PARITY_EN
            parity_d    = (^hold_q) ^ parity_odd_in;
`endif
            tx_d        = 1'b0;
            sub_d       = '0;
            state_d     = S_START;
        end
    end

    always_ff @(posedge clock_in) begin
        if (!n_reset_in) begin
            state_q     <= S_IDLE;
            sub_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            two_stop_q  <= 1'b0;
            stop2_q     <= 1'b0;
            tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            two_stop_q  <= two_stop_d;
            stop2_q     <= stop2_d;
            tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign ready_out = !hold_full_q;
    assign busy_out  = (state_q != S_IDLE) || hold_full_q;
    assign tx_out    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: vector table plus scoreboard for an 8-bit uart_tx, and a hand sequence on a 5-bit instance.
module tb_uart_tx;

    localparam int unsigned TICK_DIV = 10;
    localparam int unsigned BOUND    = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;
    logic tick = 1'b0;
    int unsigned tick_cnt = 0;
    logic tick_d = 1'b0;
    logic rst_d = 1'b0;

    always @(posedge clk) begin
        if (tick_cnt == TICK_DIV - 1) begin
            tick_cnt <= 0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1;
            tick     <= 1'b0;
        end
        tick_d <= tick;
        rst_d  <= n_rst;
    end

    logic [7:0] data8;
    logic       valid8, ready8, ts8, tx8, busy8;
    logic [4:0] data5;
    logic       valid5, ready5, ts5, tx5, busy5;
`ifdef UART_TX_PARITY_EN
    logic       odd8, odd5;
`endif

    uart_tx #(.DATA_BITS(8)) dut (
        .clock_in    (clk),
        .n_reset_in  (n_rst),
        .tick_in     (tick),
        .data_in     (data8),
        .valid_in    (valid8),
        .ready_out   (ready8),
        .two_stop_in (ts8),
`ifdef UART_TX_PARITY_EN
        .parity_odd_in (odd8),
`endif
        .tx_out      (tx8),
        .busy_out    (busy8)
    );

    uart_tx #(.DATA_BITS(5)) dut5 (
        .clock_in    (clk),
        .n_reset_in  (n_rst),
        .tick_in     (tick),
        .data_in     (data5),
        .valid_in    (valid5),
        .ready_out   (ready5),
        .two_stop_in (ts5),
`ifdef UART_TX_PARITY_EN
        .parity_odd_in (odd5),
`endif
        .tx_out      (tx5),
        .busy_out    (busy5)
    );

    typedef struct {
        logic [7:0] data;
        logic       two_stop;
        logic       odd;
        logic       b2b;
        int         exp_stops;
        logic       exp_par;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        int         stops;
        logic       par;
        logic       b2b;
    } frame_t;

    frame_t sb[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles, expected event", name, BOUND);
    endtask

    task automatic wait_tick();
        int unsigned t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!tick_d && t < 100);
        if (!tick_d) timeout("wait_tick");
    endtask

    // Monitor: samples tx8 once per tick and lines it up against the queued frame.
    logic        exp_bits [0:15];
    int          nb, bpos, sub;
    int unsigned tick_num = 0, end_tick = 0;
    logic        mon_active = 1'b0, end_pending = 1'b0;
    frame_t      f;

    always @(negedge clk) begin
        if (!rst_d) begin
            mon_active  = 1'b0;
            end_pending = 1'b0;
            sb.delete();
        end else if (tick_d) begin
            tick_num++;
            if (mon_active) begin
                check($sformatf("frame_%02h_bit%0d_s%0d", f.data, bpos, sub), tx8, exp_bits[bpos]);
                if (sub == 2) check($sformatf("busy_frame_%02h_bit%0d", f.data, bpos), busy8, 1);
                sub++;
                if (sub == 4) begin
                    sub = 0;
                    bpos++;
                    if (bpos == nb) begin
                        mon_active  = 1'b0;
                        end_tick    = tick_num;
                        end_pending = 1'b1;
                    end
                end
            end else begin
                if (end_pending) begin
                    end_pending = 1'b0;
                    if (sb.size() == 0) begin
                        check("busy_after_frame", busy8, 0);
                        check("idle_after_frame", tx8, 1);
                    end
                end
                if (tx8 === 1'b0) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_start: tx=0 at tick %0d, expected idle 1", tick_num);
                    end else begin
                        f = sb.pop_front();
                        if (f.b2b) check($sformatf("gap_before_%02h", f.data), tick_num, end_tick + 1);
                        exp_bits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) exp_bits[1 + i] = f.data[i];
                        nb = 9;
`ifdef UART_TX_PARITY_EN
                        exp_bits[nb] = f.par;
                        nb++;
`endif
                        for (int i = 0; i < f.stops; i++) begin
                            exp_bits[nb] = 1'b1;
                            nb++;
                        end
                        mon_active = 1'b1;
                        bpos = 0;
                        sub  = 1;
                    end
                end
            end
        end
    end

    task automatic send8(input vec_t v);
        int unsigned t;
        if (!v.b2b) begin
            t = 0;
            while (busy8 && t < BOUND) begin @(negedge clk); t++; end
            if (busy8) timeout("idle_before_send");
            repeat (3) @(negedge clk);
        end
        ts8 = v.two_stop;
`ifdef UART_TX_PARITY_EN
        odd8 = v.odd;
`endif
        data8  = v.data;
        valid8 = 1'b1;
        t = 0;
        while (!ready8 && t < BOUND) begin @(negedge clk); t++; end
        if (!ready8) begin
            timeout("accept");
            valid8 = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back('{data: v.data, stops: v.exp_stops, par: v.exp_par, b2b: v.b2b});
        @(negedge clk);
        valid8 = 1'b0;
        data8  = 8'($urandom);
        check($sformatf("ready_after_accept_%02h", v.data), ready8, 0);
        t = 0;
        while (!ready8 && t < BOUND) begin @(negedge clk); t++; end
        if (!ready8) timeout("load");
        // the frame is now latched; flipping config here must not disturb it
        ts8 = ~v.two_stop;
`ifdef UART_TX_PARITY_EN
        odd8 = ~v.odd;
`endif
    endtask

    vec_t vecs [8];
    logic exp5 [0:6];
    logic [4:0] d5;

    initial begin
        vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[2] = '{8'h0F, 1'b0, 1'b1, 1'b1, 1, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b0, 2, 1'b0};
        vecs[4] = '{8'h07, 1'b0, 1'b0, 1'b1, 1, 1'b1};
        vecs[5] = '{8'h07, 1'b0, 1'b1, 1'b1, 1, 1'b0};
        vecs[6] = '{8'h81, 1'b1, 1'b1, 1'b1, 2, 1'b1};
        vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0};

        n_rst  = 1'b0;
        data8  = 8'hEE;
        valid8 = 1'b1;
        ts8    = 1'b0;
        data5  = 5'h1F;
        valid5 = 1'b1;
        ts5    = 1'b0;
`ifdef UART_TX_PARITY_EN
        odd8 = 1'b0;
        odd5 = 1'b0;
`endif
        repeat (4) @(negedge clk);
        check("reset_tx", tx8, 1);
        check("reset_ready", ready8, 1);
        check("reset_busy", busy8, 0);
        check("reset_tx5", tx5, 1);
        check("reset_busy5", busy5, 0);
        valid8 = 1'b0;
        valid5 = 1'b0;
        n_rst  = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) send8(vecs[i]);

        // Tick coincident with acceptance on the 5-bit instance
        begin
            int unsigned t = 0;
            while (!(tick && ready5 && !busy5) && t < BOUND) begin @(negedge clk); t++; end
            if (t >= BOUND) timeout("coinc_align");
            d5 = 5'h15;
            data5  = d5;
            valid5 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            valid5 = 1'b0;
            check("coinc_tx_idle", tx5, 1);
            check("coinc_busy", busy5, 1);
            exp5[0] = 1'b0;
            for (int i = 0; i < 5; i++) exp5[1 + i] = d5[i];
            exp5[6] = 1'b1;
            wait_tick();
            for (int b = 0; b < 7; b++) begin
                for (int s = 0; s < 4; s++) begin
                    check($sformatf("d5_bit%0d_s%0d", b, s), tx5, exp5[b]);
                    wait_tick();
                end
            end
            check("d5_busy_end", busy5, 0);
            check("d5_idle_end", tx5, 1);
        end

        // Reset during DATA bit 3 while the holding register is full
        begin
            vec_t r;
            r = '{8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b0};
            send8(r);
            data8  = 8'h5A;
            valid8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            valid8 = 1'b0;
            check("mid_hold_full", ready8, 0);
            repeat (16) wait_tick();
            n_rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("midrst_tx", tx8, 1);
            check("midrst_ready", ready8, 1);
            check("midrst_busy", busy8, 0);
            repeat (2) @(negedge clk);
            n_rst = 1'b1;
            repeat (60) wait_tick();
            check("post_reset_tx", tx8, 1);
            check("post_reset_busy", busy8, 0);
            r = '{8'h3C, 1'b0, 1'b1, 1'b0, 1, 1'b1};
            send8(r);
        end

        begin
            int unsigned t = 0;
            while ((mon_active || end_pending || busy8) && t < BOUND) begin @(negedge clk); t++; end
            if (t >= BOUND) timeout("final_drain");
        end
        repeat (20) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter that consumes the 4x-oversampled baud strobe from the team's baud generator.
- Serializes parallel words as LSB-first async frames: start bit, data, optional parity, 1 or 2 stop bits.
- A one-entry holding register decouples the parallel valid/ready handshake from bit timing, so back-to-back frames are gap-free.
- Sits between a host-side byte source (FIFO or register interface) and the TXD pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clock_in  input  1  positive edge-triggered system clock
- n_reset_in  input  1  active-low synchronous reset
- tick_in  input  1  one-clock strobe at 4x baud rate; 4 ticks = 1 bit time
- data_in  input  DATA_BITS  word to transmit
- valid_in  input  1  data_in valid
- ready_out  output  1  holding register empty; transfer occurs when valid_in && ready_out
- two_stop_in  input  1  1 = two stop bits, 0 = one stop bit; sampled when a word moves from hold into the shifter
- tx_out  output  1  serial line, idle high, registered
- busy_out  output  1  high while a frame is in progress or the holding register is full

Interface:
- One clock; reset is synchronous and active-low, named clock_in / n_reset_in.

Behaviour:
- Reset (n_reset_in low at a clock edge):
  - tx_out=1, ready_out=1, busy_out=0, state=IDLE, hold empty, sub-counter=0.
  - Inputs are ignored while n_reset_in is low.
  - Reset mid-frame aborts the frame: tx_out=1 on that edge, and the pending hold word is discarded.
- Handshake:
  - ready_out = !hold_full.
  - On an edge with valid_in && ready_out, data_in is latched into hold and hold_full is set.
  - The hold register may accept during any shifter state.
- Timing:
  - All shifter activity advances only on edges where tick_in=1.
  - A 2-bit sub-counter counts ticks within a bit; a bit ends on the edge where tick_in=1 and sub=3.
  - tx_out changes only on bit-boundary edges. Each bit is exactly 4 tick periods.
- States:
  - IDLE: on a tick edge with hold_full, load the shifter from hold, clear hold_full, latch two_stop_in (and parity config), drive tx_out=0, go to START, sub=0.
    - A tick on the same edge as acceptance is not used; start begins at the first tick strictly after the acceptance edge.
  - START: at bit end, tx_out=data bit0, go to DATA, bit index=0.
  - DATA: at bit end, if index==DATA_BITS-1, go to PARITY (if compiled in) or STOP with tx_out=1; else index+1 and shift the next bit out.
  - PARITY: at bit end, tx_out=1, go to STOP.
  - STOP: 1 or 2 bit times (per latched two_stop).
    - At its final bit end: if hold_full, load as in IDLE and go directly to START, so the next start bit immediately follows the stop bit.
    - Otherwise go to IDLE.
- busy_out = (state != IDLE) || hold_full.
- Changes to two_stop_in mid-frame do not affect the current frame.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - Adds input parity_odd_in (1 bit), sampled at shifter load.
  - Inserts one PARITY bit after the data bits: XOR of the data bits for even parity, inverted when parity_odd_in=1.
- Undefined:
  - No parity_odd_in port and no PARITY state; DATA goes straight to STOP.

Test Plan:
- Basic frame:
  - Stimulus: tick every 10 clocks, DATA_BITS=8, two_stop=0; send 0x55.
  - Response: tx_out after the first post-accept tick shows 0,1,0,1,0,1,0,1,0,1; each level lasts 40 clocks; returns to idle high; busy_out falls after 40 ticks total.
- Back-to-back:
  - Stimulus: valid_in held high with 0xA3 then 0x0F.
  - Response: second word accepted while the first is shifting; ready_out=0 until the first frame loads; the second start bit begins on the same edge the first stop bit ends, with no idle gap.
- Two stop bits:
  - Stimulus: send 0xFF with two_stop_in=1.
  - Response: start=0, eight 1s, stop high for 8 ticks before the next start; toggling two_stop_in mid-frame has no effect.
- Parity (UART_TX_PARITY_EN):
  - Stimulus: send 0x07.
  - Response: parity bit=1 with parity_odd_in=0 and 0 with parity_odd_in=1; frame length 11 bits (44 ticks).
- Reset mid-frame:
  - Stimulus: assert n_reset_in low during DATA bit 3 with hold full.
  - Response: tx_out=1, ready_out=1, busy_out=0 on the next edge; no remnant bits after release; a new word 0x3C transmits correctly.
- Tick/accept coincidence:
  - Stimulus: valid_in in the same cycle as tick_in while IDLE.
  - Response: start bit begins at the following tick, not the coincident one; DATA_BITS=5 run of 0x15 shows exactly 5 data bits.
